// File: rtl/vc_input_unit.sv
// vc_input_unit
// Requester side of the switch-allocation handshake for one router input port.
// Incoming flits are buffered in one FIFO per virtual channel. The route of a
// packet is taken from its head flit. Each non-empty VC with a known route and
// downstream credit raises one bit of a one-hot-per-VC request vector. The
// granted flit is popped, forwarded one cycle later, and a credit is returned
// upstream for it.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_vc/in_head/in_tail/in_dest/in_data   incoming flit link
//   dn_ready[NUM_REQ]  downstream credit available per (port,vc)
//   req[NUM_REQ]       requests to switch arbiter, index = port*CHANNELS+vc
//   gnt[NUM_REQ]       grant from arbiter (combinational answer to req)
//   adj[NUM_REQ]       arbiter priority-update strobe (granted tail flit)
//   out_valid/out_port/out_vc/out_head/out_tail/out_data   forwarded flit
//   credit_valid/credit_vc   one credit returned upstream per popped flit
//   err                sticky protocol-error flag
//
// Handshake: req is a function of registered state and dn_ready only. A
// transfer happens at a clk edge where exactly one gnt bit is set and that
// bit's req is also set; any other non-zero gnt is ignored and flags err.
module vc_input_unit #(
   parameter int PORTS    = 5,
   parameter int CHANNELS = 12,
   parameter int DEPTH    = 4,
   parameter int DATA_W   = 32,
   localparam int NUM_REQ = PORTS * CHANNELS,
   localparam int VC_W    = $clog2(CHANNELS),
   localparam int PT_W    = $clog2(PORTS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [VC_W-1:0]    in_vc,
   input  logic               in_head,
   input  logic               in_tail,
   input  logic [PT_W-1:0]    in_dest,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [NUM_REQ-1:0] dn_ready,
   output logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] gnt,
   output logic [NUM_REQ-1:0] adj,
   output logic               out_valid,
   output logic [PT_W-1:0]    out_port,
   output logic [VC_W-1:0]    out_vc,
   output logic               out_head,
   output logic               out_tail,
   output logic [DATA_W-1:0]  out_data,
   output logic               credit_valid,
   output logic [VC_W-1:0]    credit_vc,
   output logic               err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              head;
      logic              tail;
      logic [PT_W-1:0]   dest;
      logic [DATA_W-1:0] data;
   } flit_t;

   flit_t             mem       [CHANNELS][DEPTH];
   logic [PTR_W-1:0]  rd_ptr    [CHANNELS];
   logic [PTR_W-1:0]  wr_ptr    [CHANNELS];
   logic [CNT_W-1:0]  count     [CHANNELS];
   logic [PT_W-1:0]   route_reg [CHANNELS];
   logic [CHANNELS-1:0] route_valid;

   flit_t             hd        [CHANNELS];
   logic [PT_W-1:0]   eff_route [CHANNELS];
   logic [CHANNELS-1:0] nonempty, full, can_req, hd_tail, route_err, wr_sel;
   logic [CHANNELS-1:0] do_pop, wr_ok;

   // Per-VC view of the FIFO head. A head flit always routes by its own dest
   // (even if a stale route is still latched), body/tail flits use the
   // latched route. route_err covers both broken-framing cases: head while a
   // packet is open, or non-head while no packet is open.
   always_comb begin
      for (int v = 0; v < CHANNELS; v++) begin
         hd[v]        = mem[v][rd_ptr[v]];
         nonempty[v]  = (count[v] != '0);
         full[v]      = (count[v] == CNT_W'(DEPTH));
         hd_tail[v]   = hd[v].tail;
         eff_route[v] = hd[v].head ? hd[v].dest : route_reg[v];
         can_req[v]   = nonempty[v] & (hd[v].head | route_valid[v]);
         route_err[v] = nonempty[v] & (hd[v].head == route_valid[v]);
         wr_sel[v]    = in_valid & (in_vc == VC_W'(v));
      end
   end

   logic [NUM_REQ-1:0]                hit;
   logic [CHANNELS-1:0][PORTS-1:0]    hit_pv;
   logic [PORTS-1:0]                  hit_pp;

   assign hit = gnt & req;

   for (genvar gp = 0; gp < PORTS; gp++) begin : g_port
      assign hit_pp[gp] = |hit[gp*CHANNELS +: CHANNELS];
      for (genvar gv = 0; gv < CHANNELS; gv++) begin : g_vc
         assign req[gp*CHANNELS+gv] = can_req[gv] & (eff_route[gv] == PT_W'(gp))
                                      & dn_ready[gp*CHANNELS+gv];
         assign adj[gp*CHANNELS+gv] = gnt[gp*CHANNELS+gv] & req[gp*CHANNELS+gv]
                                      & hd_tail[gv];
         assign hit_pv[gv][gp]      = hit[gp*CHANNELS+gv];
      end
   end

   // A grant is honoured only when it is exactly one-hot and lands on a
   // raised request; (x & (x-1)) == 0 tests for at most one set bit.
   logic gnt_onehot, pop_ok, gnt_err, overflow, bad_vc;
   assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - NUM_REQ'(1))) == '0);
   assign pop_ok     = gnt_onehot & (|hit);
   assign gnt_err    = (gnt != '0) & ~pop_ok;
   assign bad_vc     = in_valid & (int'(in_vc) >= CHANNELS);

   logic [VC_W-1:0] pop_vc;
   logic [PT_W-1:0] pop_port;
   flit_t           pop_flit;

   always_comb begin
      pop_vc   = '0;
      pop_port = '0;
      pop_flit = '0;
      do_pop   = '0;
      wr_ok    = '0;
      for (int v = 0; v < CHANNELS; v++) begin
         do_pop[v] = pop_ok & (|hit_pv[v]);
         // A full FIFO still accepts a write when it pops in the same cycle.
         wr_ok[v]  = wr_sel[v] & (~full[v] | do_pop[v]);
         if (do_pop[v]) begin
            pop_vc   = VC_W'(v);
            pop_flit = hd[v];
         end
      end
      for (int p = 0; p < PORTS; p++) begin
         if (hit_pp[p]) pop_port = PT_W'(p);
      end
   end

   assign overflow = |(wr_sel & full & ~do_pop);

   // Flit storage carries no reset: validity is tracked by count.
   always_ff @(posedge clk) begin
      for (int v = 0; v < CHANNELS; v++) begin
         if (!rst && wr_ok[v]) mem[v][wr_ptr[v]] <= {in_head, in_tail, in_dest, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < CHANNELS; v++) begin
            rd_ptr[v]    <= '0;
            wr_ptr[v]    <= '0;
            count[v]     <= '0;
            route_reg[v] <= '0;
         end
         route_valid  <= '0;
         err          <= 1'b0;
         out_valid    <= 1'b0;
         out_port     <= '0;
         out_vc       <= '0;
         out_head     <= 1'b0;
         out_tail     <= 1'b0;
         out_data     <= '0;
         credit_valid <= 1'b0;
         credit_vc    <= '0;
      end else begin
         for (int v = 0; v < CHANNELS; v++) begin
            if (wr_ok[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
            if (do_pop[v]) begin
               rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
               if (hd[v].head) route_reg[v] <= hd[v].dest;
               // Tail pop closes the packet; a single-flit packet never opens one.
               route_valid[v] <= ~hd[v].tail;
            end
            case ({wr_ok[v], do_pop[v]})
               2'b10:   count[v] <= count[v] + CNT_W'(1);
               2'b01:   count[v] <= count[v] - CNT_W'(1);
               default: count[v] <= count[v];
            endcase
         end
         err          <= err | gnt_err | overflow | bad_vc | (|route_err);
         out_valid    <= pop_ok;
         credit_valid <= pop_ok;
         if (pop_ok) begin
            out_port  <= pop_port;
            out_vc    <= pop_vc;
            out_head  <= pop_flit.head;
            out_tail  <= pop_flit.tail;
            out_data  <= pop_flit.data;
            credit_vc <= pop_vc;
         end
      end
   end

endmodule

// File: doc/vc_input_unit.md
Name: vc_input_unit

Overview:
- Requester side of the switch-allocation handshake for one router input port.
- Buffers incoming flits in per-VC FIFOs and latches each packet's route on its head flit.
- Drives a one-hot request vector of width PORTS*CHANNELS into the switch arbiter, consumes the returned grant, and forwards the granted flit.
- Returns one credit upstream per popped flit and flags the arbiter priority update on tail flits.

Parameters:
- PORTS, 5, number of router output ports.
- CHANNELS, 12, virtual channels per port.
- DEPTH, 4, flit slots per VC FIFO (power of two, >=2).
- DATA_W, 32, flit payload width.
- NUM_REQ, PORTS*CHANNELS (localparam), arbiter request width; index = dest_port*CHANNELS + vc.
- VC_W, PT_W, $clog2(CHANNELS), $clog2(PORTS) (localparams).

Ports:
- clk input 1 clock.
- rst input 1 synchronous active-high reset.
- in_valid input 1 flit present on input link.
- in_vc input VC_W target VC of incoming flit.
- in_head input 1 head-flit marker.
- in_tail input 1 tail-flit marker (head+tail = single-flit packet).
- in_dest input PT_W output port; sampled only on head flits.
- in_data input DATA_W payload.
- dn_ready input NUM_REQ downstream VC has credit, one bit per (port,vc).
- req output NUM_REQ requests to switch arbiter.
- gnt input NUM_REQ grant from arbiter; combinational response to req.
- adj output NUM_REQ priority-update strobe to arbiter.
- out_valid output 1 forwarded flit valid.
- out_port output PT_W destination port of forwarded flit.
- out_vc output VC_W VC of forwarded flit.
- out_head output 1 head marker of forwarded flit.
- out_tail output 1 tail marker of forwarded flit.
- out_data output DATA_W payload of forwarded flit.
- credit_valid output 1 one credit returned upstream.
- credit_vc output VC_W VC of returned credit.
- err output 1 sticky protocol-error flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All FIFOs empty, pointers/counts 0, route registers 0, route_valid 0.
  - out_valid, credit_valid and err are 0; all registered outputs are 0.
  - Reset mid-packet flushes all buffered flits; no credits are returned for flushed flits.
- FIFO write: a flit with in_valid=1 is written to FIFO[in_vc] at the clk edge.
  - Write to a full FIFO with no same-cycle pop: flit dropped, err<=1.
  - Write and pop on the same VC in the same cycle: both occur, count unchanged; a full FIFO accepts the write.
- Route latch, per VC:
  - When the FIFO head is a head flit and route_valid=0, route takes the head flit's dest combinationally and route_valid<=1 when that flit pops.
  - route_valid clears when the tail flit pops.
  - Head flit at FIFO head while route_valid=1 (missing tail): err<=1; the new route replaces the old one.
  - Non-head flit at FIFO head while route_valid=0: err<=1, flit is not requested.
- Request, per VC v with FIFO non-empty:
  - req[route*CHANNELS+v] = dn_ready[route*CHANNELS+v]. At most CHANNELS bits of req are set.
  - req is combinational from registered state plus dn_ready; it does not depend on gnt.
- Grant:
  - At most one gnt bit is set per cycle.
  - gnt[i] with req[i]=1 pops FIFO[i mod CHANNELS] at that edge.
  - gnt[i] with req[i]=0, or more than one gnt bit set: ignored, no pop, err<=1.
- adj[i] = gnt[i] & req[i] & head_is_tail, combinational. The arbiter therefore only rotates priority at packet end.
- Output:
  - The popped flit appears on out_* with out_valid=1 the cycle after the grant (1-cycle registered latency).
  - credit_valid=1 with credit_vc equal to the popped VC in the same cycle as out_valid.
  - Both deassert the following cycle unless another grant occurred.
- Latency: flit written at edge N is requestable in cycle N+1; if granted in cycle N+1 it appears on out_* in cycle N+2.
- Pointer wrap: read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- err clears only on reset.

Test Plan:
- Single-flit packet (head=tail=1, vc=3, dest=2, data=0xA5A5A5A5), dn_ready all 1, arbiter grants immediately:
  - req[27]=1 in cycle 1, adj[27]=1.
  - Cycle 2: out_valid=1, out_port=2, out_vc=3, out_data=0xA5A5A5A5, credit_valid=1, credit_vc=3.
- 3-flit packet on vc=0 to dest=4 with dn_ready[48]=0 for 5 cycles:
  - req stays 0 during that time.
  - After dn_ready[48]=1 with continuous grants: 3 consecutive out_valid cycles, out_port=4 each, adj[48]=1 only on the tail grant.
- Fill vc=5 with 4 flits (DEPTH=4), then write a 5th with no pop:
  - Flit dropped, err=1, count stays 4.
  - Same scenario but with a same-cycle grant on vc=5: no err, count stays 4.
- Interleaved packets on vc=1 (dest=0) and vc=2 (dest=1):
  - Grants alternate; each output flit keeps its own VC's latched route.
  - Credits are returned to VC 1 and VC 2 in grant order.
- gnt[10] asserted while req[10]=0:
  - No pop, out_valid=0 next cycle, err=1.
- rst asserted mid-packet with 2 flits buffered in vc=7:
  - All req=0 next cycle, out_valid=0, no credit returned.
  - A new head flit on vc=7 is then accepted normally.
